// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, (MEM), WB and takes
// traps/interrupts only at instruction boundaries.
//
// Optional feature: define SEQ_BUS_TIMEOUT_EN to add a bus wait timeout of
// TIMEOUT_CYCLES request cycles on both the fetch and load/store handshakes.
// Without it the sequencer waits indefinitely for an ack.
//
// Ports:
//   clk, rst_n                  core clock, async active-low reset
//   run_i, halt_i, irq_i        start/resume, stop request, external interrupt
//   ifu_req_o/ack_i/err_i       instruction fetch handshake
//   ir_we_o                     instruction register load
//   dec_*_i                     registered decoder outputs
//   lsu_req_o/we_o/ack_i/err_i  load/store handshake
//   pc_we_o, rf_we_o, csr_we_o  datapath write strobes
//   trap_o, trap_cause_o        trap entry strobe and {interrupt, code}
//   instret_o                   retire pulse
//   state_o                     current state for debug
module core_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  input  logic       halt_i,
  input  logic       irq_i,
  output logic       ifu_req_o,
  input  logic       ifu_ack_i,
  input  logic       ifu_err_i,
  output logic       ir_we_o,
  input  logic       dec_load_i,
  input  logic       dec_store_i,
  input  logic       dec_reg_w_en_i,
  input  logic       dec_csr_we_i,
  input  logic       dec_ecall_i,
  output logic       lsu_req_o,
  output logic       lsu_we_o,
  input  logic       lsu_ack_i,
  input  logic       lsu_err_i,
  output logic       pc_we_o,
  output logic       rf_we_o,
  output logic       csr_we_o,
  output logic       trap_o,
  output logic [4:0] trap_cause_o,
  output logic       instret_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExec   = 4'd3,
    StMem    = 4'd4,
    StWb     = 4'd5,
    StTrap   = 4'd6,
    StHalt   = 4'd7
  } state_e;

  localparam logic [4:0] CauseFetchFault = 5'h01;
  localparam logic [4:0] CauseLoadFault  = 5'h05;
  localparam logic [4:0] CauseStoreFault = 5'h07;
  localparam logic [4:0] CauseEcall      = 5'h0B;
  localparam logic [4:0] CauseExtIrq     = 5'h1B;

  state_e     state_q, state_d;
  // Cause is latched on the edge that enters TRAP and held until the next trap.
  logic [4:0] cause_q, cause_d;
  logic       timeout;

`ifdef SEQ_BUS_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 16) ? 16 : CntRaw);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] wait_q, wait_d;

  // wait_q counts request cycles already spent without ack; the cycle where it
  // hits TIMEOUT_CYCLES-1 is the last request cycle.
  assign timeout = (wait_q == CntLimit);

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if ((state_q == StFetch) || (state_q == StMem)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    ifu_req_o = 1'b0;
    ir_we_o   = 1'b0;
    lsu_req_o = 1'b0;
    lsu_we_o  = 1'b0;
    pc_we_o   = 1'b0;
    rf_we_o   = 1'b0;
    csr_we_o  = 1'b0;
    trap_o    = 1'b0;
    instret_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        ifu_req_o = 1'b1;
        if (ifu_ack_i) begin
          if (ifu_err_i) begin
            state_d = StTrap;
            cause_d = CauseFetchFault;
          end else begin
            ir_we_o = 1'b1;
            state_d = StDecode;
          end
        end else if (timeout) begin
          state_d = StTrap;
          cause_d = CauseFetchFault;
        end
      end
      StDecode: begin
        state_d = StExec;
      end
      StExec: begin
        if (dec_ecall_i) begin
          state_d = StTrap;
          cause_d = CauseEcall;
        end else if (dec_load_i || dec_store_i) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        lsu_req_o = 1'b1;
        lsu_we_o  = dec_store_i;
        if ((lsu_ack_i && lsu_err_i) || (!lsu_ack_i && timeout)) begin
          state_d = StTrap;
          cause_d = dec_store_i ? CauseStoreFault : CauseLoadFault;
        end else if (lsu_ack_i) begin
          state_d = StWb;
        end
      end
      StWb: begin
        pc_we_o   = 1'b1;
        rf_we_o   = dec_reg_w_en_i;
        csr_we_o  = dec_csr_we_i;
        instret_o = 1'b1;
        if (halt_i) begin
          state_d = StHalt;
        end else if (irq_i) begin
          state_d = StTrap;
          cause_d = CauseExtIrq;
        end else begin
          state_d = StFetch;
        end
      end
      StTrap: begin
        trap_o   = 1'b1;
        pc_we_o  = 1'b1;
        csr_we_o = 1'b1;
        state_d  = StFetch;
      end
      StHalt: begin
        if (run_i && !halt_i) state_d = StFetch;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign trap_cause_o = cause_q;
  assign state_o      = state_q;

endmodule
